// File: rtl/rom_streamer.sv
// Streams a burst of words out of a combinational ROM with a valid/ready handshake.
// One word every two cycles (fetch, then send), with a running XOR checksum of the burst.
module rom_streamer #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W:0]   remain;

    assign rom_addr = addr_cnt;

    // busy and done are registered alongside the state so they are glitch-free
    // and never depend combinationally on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            remain    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            checksum  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        checksum <= '0;
                        busy     <= 1'b1;
                        if (length != '0) begin
                            addr_cnt <= base_addr;
                            remain   <= length;
                            state    <= FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                FETCH: begin
                    out_data  <= rom_data;
                    out_valid <= 1'b1;
                    out_last  <= (remain == (ADDR_W+1)'(1));
                    checksum  <= checksum ^ rom_data;
                    addr_cnt  <= addr_cnt + ADDR_W'(1);
                    remain    <= remain - (ADDR_W+1)'(1);
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
